sram_sp512x32_arb: RTL

// - Controller/arbiter for one sram_sp512x32 single-port macro (512x32, 1 access/cycle).
// - Shares it between two requesters (p0, p1) via valid/ready; returns read data with rvalid.
// - Optional post-reset clear pass zeroes every word before serving requests.
// - Drives all macro pins; the parent instantiates this block beside the macro.

---
 rtl/sram_ctrl_pkg.sv | 15 +
 rtl/rr_arb2.sv | 32 +++
 rtl/sram_sp512x32_arb.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants and state encoding for the single-port SRAM controller family.
package sram_ctrl_pkg;

  localparam int SRAM_AW = 9;
  localparam int SRAM_DW = 32;

  localparam logic [2:0] SRAM_EMA_DEF  = 3'b011;
  localparam logic [1:0] SRAM_EMAW_DEF = 2'b01;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the port that was not granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer only moves on an actual grant, so idle cycles keep the fairness order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (gnt[0]) begin
      last <= 1'b0;
    end else if (gnt[1]) begin
      last <= 1'b1;
    end
  end

endmodule

// File: rtl/sram_sp512x32_arb.sv
// Controller for one 512x32 single-port SRAM macro: optional clear pass after reset,
// then round-robin sharing between two valid/ready requesters with a one-cycle read return.
module sram_sp512x32_arb
  import sram_ctrl_pkg::*;
#(
  parameter int         AW         = SRAM_AW,
  parameter int         DW         = SRAM_DW,
  parameter bit         INIT_CLEAR = 1'b1,
  parameter logic [2:0] EMA_VAL    = SRAM_EMA_DEF,
  parameter logic [1:0] EMAW_VAL   = SRAM_EMAW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,

  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,

  output logic          init_done,

  output logic          sram_cen,
  output logic          sram_gwen,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q,
  output logic          sram_stov,
  output logic [2:0]    sram_ema,
  output logic [1:0]    sram_emaw,
  output logic          sram_emas,
  output logic          sram_ret1n,
  output logic          sram_wabl,
  output logic [1:0]    sram_wablm
);

  localparam logic [AW-1:0] CNT_LAST = '1;

  state_e        state;
  state_e        state_nxt;
  logic [AW-1:0] cnt;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          rd_pend;
  logic          rd_owner;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_CLEAR ? ST_INIT : ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req       = 2'b00;
    if (state == ST_INIT) begin
      if (cnt == CNT_LAST) begin
        state_nxt = ST_RUN;
      end
    end else if (rst_n) begin
      req = {p1_valid, p0_valid};
    end
  end

  // Reset is folded into the pin mux so the macro is disabled while rst_n is low,
  // even though the state register already sits in INIT.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_a    = '0;
    sram_d    = '0;
    if (!rst_n) begin
      sram_cen = 1'b1;
    end else if (state == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_a    = cnt;
    end else if (gnt[0]) begin
      sram_cen  = 1'b0;
      sram_gwen = ~p0_we;
      sram_a    = p0_addr;
      sram_d    = p0_wdata;
    end else if (gnt[1]) begin
      sram_cen  = 1'b0;
      sram_gwen = ~p1_we;
      sram_a    = p1_addr;
      sram_d    = p1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend  <= (gnt[0] & ~p0_we) | (gnt[1] & ~p1_we);
      rd_owner <= gnt[1];
    end
  end

  assign p0_ready  = gnt[0];
  assign p1_ready  = gnt[1];
  assign p0_rvalid = rd_pend & ~rd_owner;
  assign p1_rvalid = rd_pend & rd_owner;
  assign p0_rdata  = sram_q;
  assign p1_rdata  = sram_q;
  assign init_done = (state == ST_RUN);

  assign sram_stov  = 1'b0;
  assign sram_ema   = EMA_VAL;
  assign sram_emaw  = EMAW_VAL;
  assign sram_emas  = 1'b0;
  assign sram_ret1n = 1'b1;
  assign sram_wabl  = 1'b0;
  assign sram_wablm = 2'b00;

endmodule
